// File: rtl/intrpt_controller_if.sv
// Request/acknowledge handshake and mask-register bus between the interrupt
// controller (master) and the control unit (slave).
interface intrpt_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_EXT    = 4
);
  logic                  intrpt;
  logic [DATA_WIDTH-1:0] intrpt_val;
  logic                  intrpt_ack;
  logic                  mask_we;
  logic [NUM_EXT-1:0]    mask_wdata;
  logic [NUM_EXT-1:0]    mask_q;

  modport master (
    output intrpt, intrpt_val, mask_q,
    input  intrpt_ack, mask_we, mask_wdata
  );

  modport slave (
    input  intrpt, intrpt_val, mask_q,
    output intrpt_ack, mask_we, mask_wdata
  );
endinterface

// File: rtl/intrpt_controller.sv
// MIRCore interrupt controller: opcode traps plus edge-triggered external lines,
// mask, fixed priority, req/ack presentation. EPC capture built only with INTRPT_EPC_EN.
//
// state | meaning
// IDLE  | no request presented; picks the lowest eligible pending bit
// REQ   | intrpt high, cause latched and held until intrpt_ack
module intrpt_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_EXT    = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [5:0]            opcode,
  input  logic [NUM_EXT-1:0]    ext_irq,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [NUM_EXT+2:0]    pending_q,
  output logic [DATA_WIDTH-1:0] epc,
  output logic                  halted,
  intrpt_controller_if.master   bus
);

  localparam int NUM_SRC = NUM_EXT + 3;
  localparam int IDX_W   = $clog2(NUM_SRC);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                state, state_nxt;
  logic [NUM_EXT-1:0]    prev_irq;
  logic [NUM_EXT-1:0]    mask_r;
  logic [IDX_W-1:0]      sel_idx, sel_nxt;
  logic [DATA_WIDTH-1:0] cause_r;
  logic [NUM_SRC-1:0]    set_vec, clr_vec, eligible;
  logic                  any_elig, ack_take, intrpt_o;

  assign ack_take = (state == REQ) && bus.intrpt_ack;

  assign set_vec = {ext_irq & ~prev_irq,
                    opcode == 6'b111100,
                    opcode == 6'b111011,
                    opcode == 6'b111010};

  assign eligible = pending_q & {~mask_r, 3'b111};
  assign any_elig = |eligible;

  // Descending scan so the lowest eligible index wins.
  always_comb begin
    sel_nxt = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_nxt = IDX_W'(i);
    end
  end

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_vec[i] = ack_take && (sel_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig) state_nxt = REQ;
      REQ:     if (bus.intrpt_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    intrpt_o = (state == REQ);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_irq  <= '0;
      mask_r    <= '1;
      pending_q <= '0;
      sel_idx   <= '0;
      cause_r   <= '0;
      halted    <= 1'b0;
    end else begin
      prev_irq  <= ext_irq;
      // Set wins over the acknowledge clear so a same-edge event is kept.
      pending_q <= (pending_q & ~clr_vec) | set_vec;
      if (bus.mask_we) mask_r <= bus.mask_wdata;
      if (state == IDLE && any_elig) begin
        sel_idx <= sel_nxt;
        cause_r <= DATA_WIDTH'(sel_nxt) + DATA_WIDTH'(1);
      end
      if (ack_take && sel_idx == IDX_W'(2)) halted <= 1'b1;
    end
  end

`ifdef INTRPT_EPC_EN
  logic [DATA_WIDTH-1:0] epc_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      epc_r <= '0;
    else if (state == IDLE && any_elig) epc_r <= pc;
  end

  assign epc = epc_r;
`else
  logic unused_pc;

  assign unused_pc = ^pc;
  assign epc       = '0;
`endif

  assign bus.intrpt     = intrpt_o;
  assign bus.intrpt_val = cause_r;
  assign bus.mask_q     = mask_r;

endmodule
